// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial wide adder.
//   - state_e      : controller FSM encoding
//   - NIB_W        : width of the shared adder slice
//   - idx_width()  : width of the nibble index counter (never below 1)
package wide_add_sequencer_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-nibble configuration still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b    : nibble operands
//   cin     : carry in
//   sum_c   : nibble sum
//   cout_c  : carry out of bit 3
module four_bit_adder
  import wide_add_sequencer_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum_c,
  output logic             cout_c
);

  logic carry;

  // Bit-serial ripple through the slice.
  always_comb begin
    sum_c = '0;
    carry = cin;
    for (int i = 0; i < int'(NIB_W); i++) begin
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout_c = carry;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one 4-bit adder slice reused once per cycle,
// least-significant nibble first, carry held in a register between nibbles.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake carrying a, b, sub
//   a, b                   : W-bit operands, W = 4*NIBBLES
//   sub                    : 0 -> a+b, 1 -> a-b
//   res_valid/res_ready    : result handshake
//   result                 : W-bit sum/difference
//   carry_out              : carry out of the top nibble (sub: 1 = no borrow)
//   overflow               : two's-complement signed overflow
//   busy                   : operation in flight (RUN or DONE)
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                   sub,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;

  logic [NIB_W-1:0] a_nib_c, b_nib_c, sum_nib_c;
  logic             cout_nib_c;

  // Select the current nibble of each operand for the shared slice.
  assign a_nib_c = a_q[NIB_W*idx_q +: NIB_W];
  assign b_nib_c = b_q[NIB_W*idx_q +: NIB_W];

  four_bit_adder u_slice (
    .a      (a_nib_c),
    .b      (b_nib_c),
    .cin    (carry_q),
    .sum_c  (sum_nib_c),
    .cout_c (cout_nib_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[NIB_W*idx_q +: NIB_W] = sum_nib_c;
        carry_d = cout_nib_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decode directly from the state register.
  assign req_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

  // Flags are forced low outside DONE so stale values never leak out.
  assign carry_out = res_valid & carry_q;
  assign overflow  = res_valid & (a_q[W-1] == b_q[W-1]) & (result_q[W-1] != a_q[W-1]);

endmodule
